mod_counter: RTL and testbench
==============================

// Module: mod_counter
// PURPOSE
//   Parametrised modulo up/down counter; successor to the fixed 6-bit up-counter.
//   Adds configurable width and modulus, direction control, synchronous clear and
//   load, wrap or saturate mode, a registered wrap pulse and a sticky overflow flag.
//   Used as the index/column counter in datapath control FSMs.
// PARAMETERS
//   WIDTH    6   counter width in bits
//   MODULUS  64  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//   SATURATE 0   0: wrap at range ends; 1: hold at range ends
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-low reset (0 = reset)
//   clear     in   1      synchronous clear of pout and ovf
//   load      in   1      load pout from load_val
//   load_val  in   WIDTH  load value
//   count_en  in   1      advance one step when high
//   up        in   1      1 = count up, 0 = count down
//   pout      out  WIDTH  registered count value
//   cout      out  1      registered one-cycle wrap/limit pulse
//   at_limit  out  1      combinational: pout at the range end in the current direction
//   ovf       out  1      sticky: set by any cout event
// BEHAVIOUR
// - All state changes on the rising edge of clk. Reset is sampled only on the edge.
// - Reset values:
//   - reset==0: pout=0, cout=0, ovf=0.
// - Per-edge priority: reset > clear > load > count_en.
//   - clear: pout=0, ovf=0, cout=0.
//   - load: pout = (load_val >= MODULUS) ? MODULUS-1 : load_val; cout=0; ovf unchanged.
//   - count_en=0 and no load or clear: pout holds; cout=0.
// - Count step (count_en=1, no load or clear), limit L = up ? MODULUS-1 : 0:
//   - pout != L: pout = pout+1 (up) or pout-1 (down); cout=0.
//   - pout == L, SATURATE=0: pout wraps to 0 (up) or MODULUS-1 (down); cout=1.
//   - pout == L, SATURATE=1: pout holds at L; cout=1 on every such blocked step.
// - Timing and flags:
//   - cout is asserted in the same cycle as the new pout value (latency 1 from count_en).
//   - ovf is set on the edge where cout is set; ovf stays set until clear or reset.
//   - at_limit = up ? (pout==MODULUS-1) : (pout==0). It is independent of count_en
//     and follows up combinationally.
// - Boundary cases:
//   - Direction change at the limit: up toggles while pout==MODULUS-1 -> at_limit drops
//     immediately; the next step counts down with no cout.
//   - MODULUS < 2**WIDTH: pout never exceeds MODULUS-1, by count or by load.
//   - load and count_en asserted together: load wins and no step occurs.
//   - clear and load asserted together: clear wins.
//   - reset asserted mid-count: the next edge returns all outputs to reset values;
//     counting resumes from 0 on the first edge after reset=1.
// - Arithmetic is unsigned WIDTH-bit. No intermediate value reaches the register
//   outside 0..MODULUS-1.
// TESTING
//   1. Defaults, reset=0 for 2 cycles, then count_en=1, up=1 for 64 cycles -> pout 1..63
//      then 0. cout=1 only in the cycle pout becomes 0. ovf=1 afterwards.
//   2. MODULUS=10, up=0 from pout=0 -> pout=9 with cout=1, then 8,7,... and at_limit=1
//      while pout==0.
//   3. MODULUS=10, SATURATE=1, up=1, hold count_en -> pout sticks at 9 and cout=1 each
//      cycle; switch up=0 -> pout=8, cout=0.
//   4. load=1, load_val=12 with MODULUS=10 -> pout=9. load together with count_en ->
//      pout=load value with no increment.
//   5. Set ovf, then clear=1 together with load=1, load_val=5 -> pout=0, ovf=0, cout=0.
//   6. reset=0 mid-count at pout=37 -> next edge pout=0, cout=0, ovf=0. After reset=1,
//      counting restarts at 1.

Source files
------------

// File: rtl/mod_counter_if.sv
// mod_counter_if: control and status bundle for the modulo counter
interface mod_counter_if #(parameter int WIDTH = 6);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             count_en;
  logic             up;
  logic [WIDTH-1:0] pout;
  logic             cout;
  logic             at_limit;
  logic             ovf;
  modport master (output clear, load, load_val, count_en, up, input pout, cout, at_limit, ovf);
  modport slave  (input clear, load, load_val, count_en, up, output pout, cout, at_limit, ovf);
endinterface

// File: rtl/mod_counter.sv
// mod_counter: modulo up/down counter with wrap or saturate, registered wrap pulse and sticky overflow
module mod_counter #(
  parameter int WIDTH    = 6,
  parameter int MODULUS  = 64,
  parameter int SATURATE = 0
) (
  input logic         clk,
  input logic         reset,
  mod_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  logic [WIDTH-1:0] pout, step, nxt, ld;
  logic             cout, ovf, lim;
  always_comb begin
    lim  = bus.up ? (pout == MAX) : (pout == '0);
    step = bus.up ? pout + WIDTH'(1) : pout - WIDTH'(1);
    nxt  = lim ? ((SATURATE != 0) ? pout : (bus.up ? '0 : MAX)) : step;
    // out-of-range loads clamp so the register never leaves 0..MODULUS-1
    ld   = ({1'b0, bus.load_val} >= MOD_W) ? MAX : bus.load_val;
  end
  always_ff @(posedge clk) begin
    if (!reset || bus.clear) begin
      pout <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (bus.load) begin
      pout <= ld;
      cout <= 1'b0;
    end else if (bus.count_en) begin
      pout <= nxt;
      cout <= lim;
      ovf  <= ovf | lim;
    end else begin
      cout <= 1'b0;
    end
  end
  assign bus.pout     = pout;
  assign bus.cout     = cout;
  assign bus.ovf      = ovf;
  assign bus.at_limit = lim;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed checks of default, modulo-10 wrap and modulo-10 saturating counters
module tb_mod_counter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  mod_counter_if #(.WIDTH(6)) a ();
  mod_counter_if #(.WIDTH(6)) b ();
  mod_counter_if #(.WIDTH(6)) c ();
  mod_counter #(.WIDTH(6), .MODULUS(64), .SATURATE(0)) dut_a (.clk(clk), .reset(reset), .bus(a));
  mod_counter #(.WIDTH(6), .MODULUS(10), .SATURATE(0)) dut_b (.clk(clk), .reset(reset), .bus(b));
  mod_counter #(.WIDTH(6), .MODULUS(10), .SATURATE(1)) dut_c (.clk(clk), .reset(reset), .bus(c));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b0;
    {a.clear, a.load, a.load_val, a.count_en, a.up} = '0;
    {b.clear, b.load, b.load_val, b.count_en, b.up} = '0;
    {c.clear, c.load, c.load_val, c.count_en, c.up} = '0;
    tick();
    tick();
    check("rst_pout", 32'(a.pout), 0);
    check("rst_cout", 32'(a.cout), 0);
    check("rst_ovf", 32'(a.ovf), 0);
    check("rst_at_limit_down", 32'(a.at_limit), 1);
    // full wrap of the default counter
    reset = 1'b1;
    a.count_en = 1'b1;
    a.up = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      check("up_pout", 32'(a.pout), i % 64);
      check("up_cout", 32'(a.cout), (i == 64) ? 1 : 0);
    end
    check("up_ovf", 32'(a.ovf), 1);
    a.count_en = 1'b0;
    tick();
    check("hold_cout", 32'(a.cout), 0);
    check("hold_pout", 32'(a.pout), 0);
    // modulo-10 down count from 0
    check("m10_at_limit0", 32'(b.at_limit), 1);
    b.count_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("down_pout", 32'(b.pout), (10 - i) % 10);
      check("down_cout", 32'(b.cout), (i == 1) ? 1 : 0);
    end
    check("down_at_limit", 32'(b.at_limit), 1);
    check("down_ovf", 32'(b.ovf), 1);
    b.count_en = 1'b0;
    // saturating counter sticks at 9
    c.up = 1'b1;
    c.count_en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("sat_pout", 32'(c.pout), (i > 9) ? 9 : i);
      check("sat_cout", 32'(c.cout), (i > 9) ? 1 : 0);
    end
    check("sat_at_limit", 32'(c.at_limit), 1);
    c.up = 1'b0;
    #1;
    check("dir_at_limit", 32'(c.at_limit), 0);
    tick();
    check("dir_pout", 32'(c.pout), 8);
    check("dir_cout", 32'(c.cout), 0);
    check("dir_ovf", 32'(c.ovf), 1);
    c.count_en = 1'b0;
    // loads: clamp, priority over count
    b.load = 1'b1;
    b.load_val = 6'd12;
    tick();
    check("ld_clamp", 32'(b.pout), 9);
    check("ld_cout", 32'(b.cout), 0);
    b.load_val = 6'd3;
    b.count_en = 1'b1;
    tick();
    check("ld_vs_cnt", 32'(b.pout), 3);
    b.load_val = 6'd63;
    tick();
    check("ld_max", 32'(b.pout), 9);
    check("ld_ovf_kept", 32'(b.ovf), 1);
    // clear beats load
    b.clear = 1'b1;
    b.load_val = 6'd5;
    tick();
    check("clr_pout", 32'(b.pout), 0);
    check("clr_ovf", 32'(b.ovf), 0);
    check("clr_cout", 32'(b.cout), 0);
    {b.clear, b.load, b.count_en} = '0;
    // reset mid-count
    a.count_en = 1'b1;
    repeat (37) tick();
    check("mid_pout", 32'(a.pout), 37);
    check("mid_ovf", 32'(a.ovf), 1);
    reset = 1'b0;
    tick();
    check("mrst_pout", 32'(a.pout), 0);
    check("mrst_cout", 32'(a.cout), 0);
    check("mrst_ovf", 32'(a.ovf), 0);
    reset = 1'b1;
    tick();
    check("resume_pout", 32'(a.pout), 1);
    tick();
    check("resume_pout2", 32'(a.pout), 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
